// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writer tracking, load-use stall and
// registered EX forwarding selects for an in-order pipeline.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-low reset
//   id_valid_i           ID holds a real instruction
//   id_src_i             NUM_SRC packed source indices (src n at n*REG_AW)
//   id_src_used_i        per-source "actually read" flags
//   id_dst_i, id_dst_we_i destination index and write enable
//   id_is_load_i         ID instruction is a load
//   flush_i              kill the ID instruction
//   stall_o              hold PC and IF/ID (combinational)
//   ex_valid_o           EX holds an issued instruction (registered)
//   fwd_sel_o            per-source select, 0=regfile, k=stage k (registered)
//   perf_stall_cnt_o     stall cycle count (HAZARD_SCOREBOARD_PERF_EN only)
//   perf_fwd_cnt_o       forwarded issue count (HAZARD_SCOREBOARD_PERF_EN only)
//
// Optional feature macro: HAZARD_SCOREBOARD_PERF_EN adds saturating
// performance counters.
module hazard_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
    input  logic [NUM_SRC-1:0]        id_src_used_i,
    input  logic [REG_AW-1:0]         id_dst_i,
    input  logic                      id_dst_we_i,
    input  logic                      id_is_load_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic                      ex_valid_o,
`ifdef HAZARD_SCOREBOARD_PERF_EN
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
    output logic [31:0]               perf_stall_cnt_o,
    output logic [31:0]               perf_fwd_cnt_o
`else
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o
`endif
);

    // Slot 0 is EX; slot k sits k stages behind EX.
    logic [FWD_DEPTH:0]             slot_vld;
    logic [FWD_DEPTH:0][REG_AW-1:0] slot_dst;
    logic [FWD_DEPTH:0]             slot_ld;

    logic [NUM_SRC-1:0][FWD_DEPTH-1:0] hit;
    logic [NUM_SRC*SEL_W-1:0]          sel_next;
    logic                              load_hit;
    logic                              issue;

    // The oldest slot only exists so its writer is known to have reached
    // the regfile; nothing reads its contents.
    logic unused_tail;
    assign unused_tail = ^{slot_vld[FWD_DEPTH], slot_dst[FWD_DEPTH], slot_ld};

    always_comb begin
        hit = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                hit[n][k] = id_src_used_i[n]
                          && (|id_src_i[n*REG_AW +: REG_AW])
                          && (int'(id_src_i[n*REG_AW +: REG_AW]) < NUM_REGS)
                          && slot_vld[k]
                          && (slot_dst[k] == id_src_i[n*REG_AW +: REG_AW]);
            end
        end
    end

    // Only a load still inside its latency window blocks the consumer.
    always_comb begin
        load_hit = 1'b0;
        for (int n = 0; n < NUM_SRC; n++) begin
            for (int k = 0; k < LOAD_LAT; k++) begin
                load_hit = load_hit | (hit[n][k] & slot_ld[k]);
            end
        end
    end

    assign stall_o = id_valid_i & ~flush_i & load_hit;
    assign issue   = id_valid_i & ~stall_o & ~flush_i;

    // Walk oldest to youngest so the youngest matching writer wins.
    always_comb begin
        sel_next = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                if (hit[n][k]) begin
                    sel_next[n*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            slot_vld   <= '0;
            slot_dst   <= '0;
            slot_ld    <= '0;
            ex_valid_o <= 1'b0;
            fwd_sel_o  <= '0;
        end else begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                slot_vld[k] <= slot_vld[k-1];
                slot_dst[k] <= slot_dst[k-1];
                slot_ld[k]  <= slot_ld[k-1];
            end
            if (issue) begin
                slot_vld[0] <= id_dst_we_i & (|id_dst_i);
                slot_dst[0] <= id_dst_i;
                slot_ld[0]  <= id_is_load_i;
                fwd_sel_o   <= sel_next;
            end else begin
                slot_vld[0] <= 1'b0;
                slot_dst[0] <= '0;
                slot_ld[0]  <= 1'b0;
                fwd_sel_o   <= '0;
            end
            ex_valid_o <= issue;
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_stall_cnt_o <= '0;
            perf_fwd_cnt_o   <= '0;
        end else begin
            if (stall_o && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
            if (issue && (|sel_next) && (perf_fwd_cnt_o != 32'hFFFF_FFFF)) begin
                perf_fwd_cnt_o <= perf_fwd_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
